cmp_sample_packer: RTL and testbench

- Sits between the registered comparator outputs (cmp_data_PAD*_r, sample_clk domain) and the GTH TX data path.
- Packs 4 comparator bits per sample_clk cycle into framed 80-bit words for serial readout.
- Words are handed off on a valid/ready interface to the downstream CDC FIFO feeding gtwiz_userdata_tx_in.
- Capture is triggered by a start pulse and runs for a programmed number of words, or continuously.

---
 rtl/cmp_pack_pkg.sv | 32 +++
 rtl/cmp_sample_packer_if.sv | 12 +
 rtl/cmp_shift_accum.sv | 49 ++++
 rtl/cmp_sample_packer.sv | 154 +++++++++++++++
 tb/tb_cmp_sample_packer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pack_pkg.sv
// Shared constants, word field positions and FSM state type for the comparator sample packer.
package cmp_pack_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] IDLE_BYTE = 8'h3C;

    localparam int SAMPLES_PER_WORD = 16;
    localparam int SAMPLE_W         = 4;
    localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);
    localparam int WORD_W           = 80;

    localparam int SYNC_MSB    = 79;
    localparam int SYNC_LSB    = 72;
    localparam int SEQ_MSB     = 71;
    localparam int SEQ_LSB     = 64;
    localparam int PAYLOAD_MSB = 63;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] frame_word(
        input logic [SYNC_MSB-SYNC_LSB:0] hdr,
        input logic [SEQ_MSB-SEQ_LSB:0]   seq,
        input logic [PAYLOAD_MSB:0]       payload
    );
        frame_word = {hdr, seq, payload};
    endfunction

endpackage

// File: rtl/cmp_sample_packer_if.sv
// Framed-word valid/ready hand-off toward the CDC FIFO feeding the GTH TX user data.
interface cmp_sample_packer_if;
    import cmp_pack_pkg::*;

    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/cmp_shift_accum.sv
// Collects one 4-bit comparator sample per enabled cycle; the 16th sample completes the word
// combinationally so the top can register it on that same edge.
module cmp_shift_accum
    import cmp_pack_pkg::*;
(
    input  logic                  sample_clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [SAMPLE_W-1:0]   sample_i,
    output logic [PAYLOAD_MSB:0]  word_o,
    output logic                  done_o
);

    // The last sample bypasses the register, so only 15 samples are ever stored.
    localparam int               ACC_W    = (SAMPLES_PER_WORD - 1) * SAMPLE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        acc_d = acc_q;
        idx_d = idx_q;
        if (clear_i) begin
            acc_d = '0;
            idx_d = '0;
        end else if (en_i) begin
            acc_d = {sample_i, acc_q[ACC_W-1:SAMPLE_W]};
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

    assign word_o = {sample_i, acc_q};
    assign done_o = en_i && !clear_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/cmp_sample_packer.sv
// Packs comparator samples into framed 80-bit words with drop accounting on backpressure.
// Optional idle-word fill on the output link is enabled by defining CMP_PACK_IDLE_FILL_EN.
module cmp_sample_packer
    import cmp_pack_pkg::*;
#(
    parameter int WCNT_W = 16
) (
    input  logic                   sample_clk,
    input  logic                   reset,
    input  logic [SAMPLE_W-1:0]    cmp_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WCNT_W-1:0]      num_words,
    cmp_sample_packer_if.master    tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [WCNT_W-1:0]      drop_cnt
);

    state_t              state_q, state_d;
    logic [7:0]          seq_q, seq_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [WCNT_W-1:0]   nwords_q, nwords_d;
    logic [WCNT_W-1:0]   drop_q, drop_d;
    logic                ovf_q, ovf_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
`ifdef CMP_PACK_IDLE_FILL_EN
    logic                idle_q, idle_d;
`endif

    logic                capturing;
    logic                word_done;
    logic                hold;
    logic [PAYLOAD_MSB:0] payload;

    assign capturing = (state_q == CAPTURE);

    cmp_shift_accum u_accum (
        .sample_clk (sample_clk),
        .reset      (reset),
        .en_i       (capturing),
        .clear_i    (!capturing || abort),
        .sample_i   (cmp_data),
        .word_o     (payload),
        .done_o     (word_done)
    );

    // A pending idle word never blocks a captured word; only real data can cause a drop.
`ifdef CMP_PACK_IDLE_FILL_EN
    assign hold = valid_q && !tx.out_ready && !idle_q;
`else
    assign hold = valid_q && !tx.out_ready;
`endif

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        wcnt_d   = wcnt_q;
        nwords_d = nwords_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        data_d   = data_q;
        valid_d  = valid_q;
`ifdef CMP_PACK_IDLE_FILL_EN
        idle_d   = idle_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CAPTURE;
                    seq_d    = '0;
                    wcnt_d   = '0;
                    ovf_d    = 1'b0;
                    drop_d   = '0;
                    nwords_d = num_words;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (word_done) begin
                    seq_d  = seq_q + 8'd1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if ((nwords_q != '0) && (wcnt_d == nwords_q)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!valid_q || tx.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && tx.out_ready) valid_d = 1'b0;

        // Dropped words still consume their sequence number so the receiver sees the gap.
        if (word_done) begin
            if (hold) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + WCNT_W'(1);
            end else begin
                data_d  = frame_word(SYNC_BYTE, seq_q, payload);
                valid_d = 1'b1;
`ifdef CMP_PACK_IDLE_FILL_EN
                idle_d  = 1'b0;
`endif
            end
        end

`ifdef CMP_PACK_IDLE_FILL_EN
        if ((state_d == IDLE) && !valid_d) begin
            data_d  = frame_word(IDLE_BYTE, 8'h00, '0);
            valid_d = 1'b1;
            idle_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            seq_q    <= '0;
            wcnt_q   <= '0;
            nwords_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef CMP_PACK_IDLE_FILL_EN
            idle_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            wcnt_q   <= wcnt_d;
            nwords_q <= nwords_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
`ifdef CMP_PACK_IDLE_FILL_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign tx.out_data  = data_q;
    assign tx.out_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = ovf_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_cmp_sample_packer.sv
// Directed bench for cmp_sample_packer: table of single-word captures plus multi-cycle sequences.
module tb_cmp_sample_packer;

    localparam logic [63:0] RAMP      = 64'hFEDCBA9876543210;
    localparam logic [79:0] IDLE_WORD = {8'h3C, 72'h0};
`ifdef CMP_PACK_IDLE_FILL_EN
    localparam logic IDLE_V = 1'b1;
`else
    localparam logic IDLE_V = 1'b0;
`endif

    typedef struct {
        logic [3:0]  s;
        logic [3:0]  d;
        logic        abort_too;
        logic [63:0] payload;
    } vec_t;

    logic        sample_clk;
    logic        reset;
    logic [3:0]  cmp_data;
    logic        start;
    logic        abort;
    logic [15:0] num_words;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    cmp_sample_packer_if tx_if ();

    cmp_sample_packer #(.WCNT_W(16)) dut (
        .sample_clk (sample_clk),
        .reset      (reset),
        .cmp_data   (cmp_data),
        .start      (start),
        .abort      (abort),
        .num_words  (num_words),
        .tx         (tx_if),
        .busy       (busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    function automatic logic [79:0] exp_word(input logic [7:0] seq, input logic [63:0] p);
        return {8'hA5, seq, p};
    endfunction

    task automatic check_idle_link(input string name);
        check({name, "_valid"}, tx_if.out_valid, IDLE_V);
        if (IDLE_V) check({name, "_data"}, tx_if.out_data, IDLE_WORD);
    endtask

    // One finite single-word capture; expects seq 00 and busy low after the handshake.
    task automatic capture_one(input string name, input vec_t v);
        int t;
        num_words = 16'd1;
        tx_if.out_ready = 1'b1;
        start = 1'b1;
        abort = v.abort_too;
        for (int k = 0; k < 16; k++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            t = int'(v.s) + int'(v.d) * k;
            cmp_data = 4'(t);
            if (k == 0) check({name, "_busy"}, busy, 1'b1);
        end
        check({name, "_not_yet"}, tx_if.out_valid, 1'b0);
        tick();
        check({name, "_valid"}, tx_if.out_valid, 1'b1);
        check({name, "_word"}, tx_if.out_data, exp_word(8'h00, v.payload));
        tick();
        check({name, "_done"}, busy, 1'b0);
        check_idle_link({name, "_after"});
    endtask

    initial begin
        vec_t vecs[5];
        vec_t ramp_v;
        int   w;

        vecs[0] = '{s: 4'h0, d: 4'h1, abort_too: 1'b0, payload: 64'hFEDCBA9876543210};
        vecs[1] = '{s: 4'hF, d: 4'hF, abort_too: 1'b0, payload: 64'h0123456789ABCDEF};
        vecs[2] = '{s: 4'h5, d: 4'h0, abort_too: 1'b1, payload: 64'h5555555555555555};
        vecs[3] = '{s: 4'h0, d: 4'h2, abort_too: 1'b0, payload: 64'hECA86420ECA86420};
        vecs[4] = '{s: 4'h3, d: 4'h8, abort_too: 1'b0, payload: 64'hB3B3B3B3B3B3B3B3};
        ramp_v  = '{s: 4'h0, d: 4'h1, abort_too: 1'b0, payload: RAMP};

        reset = 1'b1;
        cmp_data = '0;
        start = 1'b0;
        abort = 1'b0;
        num_words = '0;
        tx_if.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_data", tx_if.out_data, 80'h0);
        check("rst_valid", tx_if.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop", drop_cnt, 16'h0);
        reset = 1'b0;
        tick();
        check_idle_link("idle_after_reset");

        // Basic framing: two words, later num_words change ignored
        tx_if.out_ready = 1'b1;
        num_words = 16'd2;
        start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            start = 1'b0;
            cmp_data = 4'(k);
            if (k == 1) num_words = 16'd5;
            if (k == 15) check("frame_w0_latency", tx_if.out_valid, 1'b0);
            if (k == 16) begin
                check("frame_w0_valid", tx_if.out_valid, 1'b1);
                check("frame_w0_data", tx_if.out_data, exp_word(8'h00, RAMP));
            end
            if (k == 17) check("frame_w0_taken", tx_if.out_valid, 1'b0);
        end
        tick();
        check("frame_w1_valid", tx_if.out_valid, 1'b1);
        check("frame_w1_data", tx_if.out_data, exp_word(8'h01, RAMP));
        check("frame_flush_busy", busy, 1'b1);
        tick();
        check("frame_idle_busy", busy, 1'b0);
        check_idle_link("frame_end");

        // Table of single-word captures (one also has abort alongside start)
        for (int i = 0; i < 5; i++) begin
            capture_one($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure drop
        tx_if.out_ready = 1'b0;
        num_words = 16'd3;
        start = 1'b1;
        for (int k = 0; k < 48; k++) begin
            tick();
            start = 1'b0;
            cmp_data = 4'(k);
            if (k == 32) begin
                check("bp_ovf_1", overflow, 1'b1);
                check("bp_drop_1", drop_cnt, 16'd1);
                check("bp_held_1", tx_if.out_data, exp_word(8'h00, RAMP));
            end
        end
        tick();
        check("bp_ovf", overflow, 1'b1);
        check("bp_drop", drop_cnt, 16'd2);
        check("bp_valid", tx_if.out_valid, 1'b1);
        check("bp_held", tx_if.out_data, exp_word(8'h00, RAMP));
        check("bp_flush_busy", busy, 1'b1);
        tx_if.out_ready = 1'b1;
        tick();
        check("bp_done_busy", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle_link("bp_no_more");
        end
        check("bp_ovf_sticky", overflow, 1'b1);

        // Continuous capture across sequence wrap, then abort mid-word
        num_words = 16'd0;
        start = 1'b1;
        for (int k = 0; k <= 4116; k++) begin
            tick();
            start = 1'b0;
            cmp_data = 4'(k);
            if (k == 1) begin
                check("wrap_ovf_cleared", overflow, 1'b0);
                check("wrap_drop_cleared", drop_cnt, 16'd0);
            end
            if (k >= 16 && (k % 16) == 0) begin
                w = k / 16 - 1;
                check($sformatf("wrap_w%0d_valid", w), tx_if.out_valid, 1'b1);
                check($sformatf("wrap_w%0d_data", w), tx_if.out_data, exp_word(8'(w), RAMP));
            end
            if (k == 4116) abort = 1'b1;
        end
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_idle_link("abort_no_partial");
        end

        // Asynchronous reset mid-capture
        tx_if.out_ready = 1'b0;
        num_words = 16'd0;
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            start = 1'b0;
            cmp_data = 4'(k);
            if (k == 16) check("mid_rst_valid_rose", tx_if.out_valid, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_data", tx_if.out_data, 80'h0);
        check("mid_rst_valid", tx_if.out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_drop", drop_cnt, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        capture_one("post_rst", ramp_v);

        // Same-cycle load and accept
        tx_if.out_ready = 1'b0;
        num_words = 16'd3;
        start = 1'b1;
        for (int k = 0; k < 48; k++) begin
            tick();
            start = 1'b0;
            cmp_data = 4'(k);
            if (k == 16) check("lda_w0", tx_if.out_data, exp_word(8'h00, RAMP));
            if (k == 31 || k == 47) tx_if.out_ready = 1'b1;
            if (k == 32) begin
                tx_if.out_ready = 1'b0;
                check("lda_w1_valid", tx_if.out_valid, 1'b1);
                check("lda_w1_data", tx_if.out_data, exp_word(8'h01, RAMP));
                check("lda_w1_ovf", overflow, 1'b0);
            end
        end
        tick();
        check("lda_w2_valid", tx_if.out_valid, 1'b1);
        check("lda_w2_data", tx_if.out_data, exp_word(8'h02, RAMP));
        check("lda_ovf", overflow, 1'b0);
        check("lda_drop", drop_cnt, 16'd0);
        check("lda_flush_busy", busy, 1'b1);
        tick();
        check("lda_done_busy", busy, 1'b0);
        check_idle_link("lda_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $fatal(1, "watchdog");
    end

endmodule
